axis_pack_fifo: RTL and testbench
=================================

AXIS_PACK_FIFO -- requirements
Module: axis_pack_fifo

Interface
REQ-001 SHALL have parameter IN_W, default 8, input lane width in bits.
REQ-002 SHALL have parameter RATIO, default 4, input beats packed per output word; OUT_W = IN_W*RATIO.
REQ-003 SHALL have parameter DEPTH, default 8, output-word storage entries; power of 2, >=2.
REQ-004 SHALL have parameter PKT_LEN, default 8, output words per packet; 0 disables count-based tlast.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port s_axis_tvalid  input  1  upstream beat valid.
REQ-008 SHALL have port s_axis_tdata  input  IN_W  upstream beat data.
REQ-009 SHALL have port s_axis_tlast  input  1  upstream end of packet; forces flush of the partial word.
REQ-010 SHALL have port s_axis_tready  output  1  beat accepted when high with s_axis_tvalid.
REQ-011 SHALL have port m_axis_tvalid  output  1  output word valid.
REQ-012 SHALL have port m_axis_tdata  output  OUT_W  packed word; lane 0 at LSBs.
REQ-013 SHALL have port m_axis_tkeep  output  RATIO  one bit per filled lane.
REQ-014 SHALL have port m_axis_tlast  output  1  last word of packet.
REQ-015 SHALL have port m_axis_tready  input  1  downstream accepts word.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  stored output words.

Function
REQ-017 Packer SHALL place the k-th accepted beat of a word into lane k (bits k*IN_W +: IN_W); lane counter 0..RATIO-1.
REQ-018 A word SHALL be pushed to storage on the handshake of the beat filling lane RATIO-1 or carrying s_axis_tlast; lane counter then returns to 0.
REQ-019 On a tlast flush, unfilled lanes SHALL be zero and tkeep SHALL have ones only for filled lanes; full words carry tkeep all-ones.
REQ-020 Stored tlast SHALL be 1 if the word was flushed by s_axis_tlast or is the PKT_LEN-th word since the last tlast word (PKT_LEN>0).
REQ-021 The packet word counter SHALL reset to 0 after any word pushed with tlast=1.
REQ-022 s_axis_tready SHALL equal (count < DEPTH), registered state only, no combinational dependence on s_axis_tvalid, s_axis_tlast or m_axis_tready.
REQ-023 Pushed word SHALL appear at m_axis_tvalid the cycle after the completing input handshake (latency 1).
REQ-024 m_axis_tvalid SHALL equal (count != 0); tdata/tkeep/tlast SHALL be the head entry and held stable while tvalid && !tready.
REQ-025 Pop SHALL occur on m_axis_tvalid && m_axis_tready; read pointer advances modulo DEPTH.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push-only +1, pop-only -1.
REQ-027 Write and read pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-028 When full no beat SHALL be accepted; partial-word lanes SHALL be retained unchanged until space exists.

Reset
REQ-029 rst_n high SHALL immediately clear count, pointers, lane counter, packet word counter and partial word.
REQ-030 During and after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, count=0; s_axis_tready=1 from first clock edge after rst_n falls.
REQ-031 Reset mid-operation SHALL discard stored words and partial lanes; no word emitted from pre-reset data.

Verification (IN_W=8, RATIO=4, DEPTH=8, PKT_LEN=2)
REQ-032 Beats AA,55,FF,BB, m_tready=1 -> one word 0xBBFF55AA, tkeep 0xF, tlast 0, tvalid one cycle after 4th handshake.
REQ-033 32 beats with m_tready=0 -> count reaches 8, s_axis_tready low; then m_tready=1 -> 8 words in 8 cycles, tlast on words 2,4,6,8, count 0, tvalid 0.
REQ-034 Beats 11,22,33 with tlast on 33 -> word 0x00332211, tkeep 0x7, tlast 1; next full word has tlast 0.
REQ-035 count=4, push completing beat and pop in same cycle -> count stays 4; 20 words streamed through -> pointer wrap, data in order.
REQ-036 Assert rst_n with 2 lanes packed and count=3 -> count 0, tvalid 0; after release beats 01,02,03,04 -> 0x04030201 only.

Source files
------------

// File: rtl/axis_pack_fifo.sv
// -----------------------------------------------------------------------------
// axis_pack_fifo
//
// Packs RATIO narrow AXI-Stream beats (IN_W bits each) into one OUT_W-bit word
// and stores completed words in a DEPTH-entry FIFO in front of the master
// port. An upstream tlast closes the current word early: unfilled lanes are
// zero and tkeep marks only the filled lanes. Output tlast is also raised on
// every PKT_LEN-th word since the previous tlast word (PKT_LEN = 0 disables
// this count-based tlast).
//
// Ports
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous reset, ACTIVE HIGH
//   s_axis_tvalid  upstream beat valid
//   s_axis_tdata   upstream beat data (IN_W bits)
//   s_axis_tlast   upstream end of packet; flushes the partial word
//   s_axis_tready  beat accepted when high together with s_axis_tvalid
//   m_axis_tvalid  output word valid (FIFO not empty)
//   m_axis_tdata   packed word, lane 0 at the LSBs (IN_W*RATIO bits)
//   m_axis_tkeep   one bit per filled lane
//   m_axis_tlast   last word of packet
//   m_axis_tready  downstream accepts word
//   count          number of stored output words
// -----------------------------------------------------------------------------
module axis_pack_fifo #(
    parameter int IN_W    = 8,
    parameter int RATIO   = 4,
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_axis_tvalid,
    input  logic [IN_W-1:0]            s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [IN_W*RATIO-1:0]      m_axis_tdata,
    output logic [RATIO-1:0]           m_axis_tkeep,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int OUT_W    = IN_W * RATIO;
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int LW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PW       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int PKT_LAST = (PKT_LEN > 0) ? PKT_LEN - 1 : 0;

    // packer state
    logic [LW-1:0]    lane_q;
    logic [OUT_W-1:0] part_q;
    logic [PW-1:0]    pkt_q;

    // fifo state
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             run_q;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [RATIO-1:0] mem_keep [DEPTH];
    logic             mem_last [DEPTH];

    logic             s_hs;
    logic             m_hs;
    logic             push;
    logic             lane_full;
    logic             pkt_hit;
    logic             word_last;
    logic [OUT_W-1:0] word;
    logic [RATIO-1:0] word_keep;

    // Ready is built from registers only. run_q keeps it low while reset is
    // held and releases it on the first clock edge after reset drops.
    assign s_axis_tready = run_q && (count_q < CW'(DEPTH));
    assign m_axis_tvalid = (count_q != '0);

    assign s_hs      = s_axis_tvalid && s_axis_tready;
    assign m_hs      = m_axis_tvalid && m_axis_tready;
    assign lane_full = (lane_q == LW'(RATIO - 1));
    assign push      = s_hs && (lane_full || s_axis_tlast);
    assign pkt_hit   = (PKT_LEN > 0) && (pkt_q == PW'(PKT_LAST));
    assign word_last = s_axis_tlast || pkt_hit;

    // Completed word: lanes already collected plus the current beat. Lanes
    // above the current one are still zero because part_q is cleared on
    // every push, which gives the zero padding for a tlast flush.
    always_comb begin
        word = part_q;
        word[lane_q*IN_W +: IN_W] = s_axis_tdata;
        word_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            word_keep[i] = (LW'(i) <= lane_q);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lane_q  <= '0;
            part_q  <= '0;
            pkt_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;

            if (s_hs) begin
                if (push) begin
                    lane_q <= '0;
                    part_q <= '0;
                end else begin
                    lane_q <= lane_q + LW'(1);
                    part_q <= word;
                end
            end

            if (push) begin
                // DEPTH is a power of two, so natural wrap is modulo DEPTH
                wr_ptr <= wr_ptr + AW'(1);
                pkt_q  <= word_last ? '0 : pkt_q + PW'(1);
            end

            if (m_hs) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, m_hs})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the outputs below are masked while empty, and
    // pointers/count are cleared, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= word;
            mem_keep[wr_ptr] <= word_keep;
            mem_last[wr_ptr] <= word_last;
        end
    end

    assign m_axis_tdata = m_axis_tvalid ? mem_data[rd_ptr] : '0;
    assign m_axis_tkeep = m_axis_tvalid ? mem_keep[rd_ptr] : '0;
    assign m_axis_tlast = m_axis_tvalid ? mem_last[rd_ptr] : 1'b0;
    assign count        = count_q;

endmodule

// File: tb/tb_axis_pack_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_pack_fifo
//
// Bench for axis_pack_fifo with IN_W=8, RATIO=4, DEPTH=8, PKT_LEN=2. A
// queue-based reference model (list of expected output words plus the beats
// collected for the word in progress) is compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_axis_pack_fifo;

    localparam int IN_W    = 8;
    localparam int RATIO   = 4;
    localparam int DEPTH   = 8;
    localparam int PKT_LEN = 2;

    logic        clk;
    logic        rst_n;
    logic        s_axis_tvalid;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [3:0]  count;

    axis_pack_fifo #(
        .IN_W    (IN_W),
        .RATIO   (RATIO),
        .DEPTH   (DEPTH),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [7:0]  beat_q[$];
    int          pkt_words;
    logic        mdl_run;

    task automatic model_reset();
        exp_q.delete();
        beat_q.delete();
        pkt_words = 0;
        mdl_run   = 1'b0;
    endtask

    // One clock cycle: compare DUT against model at the negedge, drive the
    // inputs, advance across the rising edge, update the model.
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic mr);
        bit    acc;
        bit    pop;
        word_t w;
        chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
        chk("count", count, exp_q.size());
        chk("s_tready", s_axis_tready, mdl_run && exp_q.size() < DEPTH);
        if (exp_q.size() != 0) begin
            chk("tdata", m_axis_tdata, exp_q[0].data);
            chk("tkeep", m_axis_tkeep, exp_q[0].keep);
            chk("tlast", m_axis_tlast, exp_q[0].last);
        end else begin
            chk("tdata_idle", m_axis_tdata, 0);
            chk("tkeep_idle", m_axis_tkeep, 0);
            chk("tlast_idle", m_axis_tlast, 0);
        end
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = mr;
        acc = v && mdl_run && (exp_q.size() < DEPTH);
        pop = (exp_q.size() != 0) && mr;
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            beat_q.push_back(d);
            if (beat_q.size() == RATIO || l) begin
                w.data = 0;
                w.keep = 0;
                for (int i = 0; i < beat_q.size(); i++) begin
                    w.data = w.data | (32'(beat_q[i]) << (8 * i));
                    w.keep[i] = 1'b1;
                end
                w.last = l || (pkt_words == PKT_LEN - 1);
                pkt_words = w.last ? 0 : pkt_words + 1;
                exp_q.push_back(w);
                beat_q.delete();
            end
        end
        mdl_run = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk(name, exp_q.size(), 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          n;
        logic [31:0] beats;
        logic        lst;
        logic [31:0] w;
        logic [3:0]  k;
        logic        l;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bts;
        tbl[0] = '{4, 32'hBBFF55AA, 1'b0, 32'hBBFF55AA, 4'hF, 1'b0};
        tbl[1] = '{3, 32'h00332211, 1'b1, 32'h00332211, 4'h7, 1'b1};
        tbl[2] = '{4, 32'h04030201, 1'b0, 32'h04030201, 4'hF, 1'b0};
        tbl[3] = '{4, 32'h40302010, 1'b0, 32'h40302010, 4'hF, 1'b1};
        tbl[4] = '{1, 32'h00000099, 1'b1, 32'h00000099, 4'h1, 1'b1};
        tbl[5] = '{2, 32'h0000A55A, 1'b1, 32'h0000A55A, 4'h3, 1'b1};
        tbl[6] = '{4, 32'hC3C2C1C0, 1'b0, 32'hC3C2C1C0, 4'hF, 1'b0};
        tbl[7] = '{4, 32'hD3D2D1D0, 1'b0, 32'hD3D2D1D0, 4'hF, 1'b1};

        rst_n         = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tkeep", m_axis_tkeep, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_count", count, 0);
        chk("rst_tready", s_axis_tready, 0);
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ready_after_rst", s_axis_tready, 1);

        // table: pack each entry, check the word, pop it
        foreach (tbl[e]) begin
            bts = tbl[e].beats;
            for (int i = 0; i < tbl[e].n; i++) begin
                chk("tbl_no_early_valid", m_axis_tvalid, 0);
                step(1'b1, bts[8*i +: 8], tbl[e].lst && (i == tbl[e].n - 1), 1'b0);
            end
            chk("tbl_valid", m_axis_tvalid, 1);
            chk("tbl_data", m_axis_tdata, tbl[e].w);
            chk("tbl_keep", m_axis_tkeep, tbl[e].k);
            chk("tbl_last", m_axis_tlast, tbl[e].l);
            step(1'b0, 8'h00, 1'b0, 1'b1);
            chk("tbl_popped", count, 0);
        end

        // fill to full, stall extra beats, then drain 8 words in 8 cycles
        for (int i = 0; i < 32; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
        chk("full_count", count, 8);
        chk("full_tready", s_axis_tready, 0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_hold_count", count, 8);
        for (int j = 0; j < 8; j++) begin
            chk("drain_tlast", m_axis_tlast, (j % 2) == 1);
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("drain_count", count, 0);
        chk("drain_tvalid", m_axis_tvalid, 0);

        // push and pop in the same cycle at count 4, then stream 20 words
        for (int i = 0; i < 19; i++) step(1'b1, 8'(i + 8'h80), 1'b0, 1'b0);
        chk("pp_pre_count", count, 4);
        step(1'b1, 8'h93, 1'b0, 1'b1);
        chk("pp_count", count, 4);
        for (int i = 0; i < 80; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        drain("stream_drained");

        // reset with 3 words stored and 2 lanes packed
        for (int i = 0; i < 14; i++) step(1'b1, 8'(i + 8'hA0), 1'b0, 1'b0);
        chk("mid_count", count, 3);
        rst_n = 1'b1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_tvalid", m_axis_tvalid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("post_rst_count", count, 1);
        chk("post_rst_data", m_axis_tdata, 32'h04030201);
        chk("post_rst_keep", m_axis_tkeep, 4'hF);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("post_rst_empty", m_axis_tvalid, 0);

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1);
        step(1'b1, 8'h5C, 1'b1, 1'b1);
        drain("rand_drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
